// File: rtl/cobs_packet_arbiter.sv
// rtl/cobs_packet_arbiter.sv - round-robin arbiter serialising 16-bit channel samples into 3-byte raw packets
module cobs_packet_arbiter #(
   parameter int NUM_CHANNELS = 4,
   localparam int ID_WIDTH = $clog2(NUM_CHANNELS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [16*NUM_CHANNELS-1:0] s_tdata,
   input  logic [NUM_CHANNELS-1:0]    s_tvalid,
   output logic [NUM_CHANNELS-1:0]    s_tready,
   output logic [7:0]                 m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic                       m_tuser,
   output logic [ID_WIDTH-1:0]        grant_id,
   output logic                       busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND_ID = 2'd1;
   localparam logic [1:0] SEND_HI = 2'd2;
   localparam logic [1:0] SEND_LO = 2'd3;

   logic [1:0]          state;
   logic [ID_WIDTH-1:0] last_grant;
   logic [ID_WIDTH-1:0] winner;
   logic [ID_WIDTH-1:0] cand;
   logic                found;
   logic [15:0]         hold;
   logic [15:0]         samples [NUM_CHANNELS];

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
      assign samples[i] = s_tdata[16*i +: 16];
   end

   // Search starts one past the previous winner and wraps, so the last winner is checked last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = last_grant;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         cand = (cand == ID_WIDTH'(NUM_CHANNELS - 1)) ? '0 : cand + 1'b1;
         if (!found && s_tvalid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      s_tready = '0;
      if (state == IDLE && found) begin
         s_tready[winner] = 1'b1;
      end
   end

   assign m_tuser = 1'b0;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         grant_id   <= '0;
         last_grant <= ID_WIDTH'(NUM_CHANNELS - 1);
         hold       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  hold       <= samples[winner];
                  grant_id   <= winner;
                  last_grant <= winner;
                  m_tdata    <= 8'(winner);
                  m_tvalid   <= 1'b1;
                  m_tlast    <= 1'b0;
                  state      <= SEND_ID;
               end
            end
            SEND_ID: begin
               if (m_tready) begin
                  m_tdata <= hold[15:8];
                  state   <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (m_tready) begin
                  m_tdata <= hold[7:0];
                  m_tlast <= 1'b1;
                  state   <= SEND_LO;
               end
            end
            default: begin
               if (m_tready) begin
                  m_tvalid <= 1'b0;
                  m_tlast  <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cobs_packet_arbiter.sv
// tb/tb_cobs_packet_arbiter.sv - self-checking bench for cobs_packet_arbiter
module tb_cobs_packet_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [63:0]   s_tdata = '0;
   logic [3:0]    s_tvalid = '0;
   logic [3:0]    s_tready;
   logic [7:0]    m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic          m_tuser;
   logic [1:0]    grant_id;
   logic          busy;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   bit check_en = 1'b0;

   // Model: pending output beats {last, data}, round-robin pointer, reported grant
   logic [8:0] mq [$];
   int         m_lg  = N - 1;
   int         m_gid = 0;

   // DUT-observed logs for literal checks
   int         glog [$];
   logic [8:0] blog [$];
   int         lcyc [$];
   int         rdy_cnt [N];

   logic [3:0] exp_rdy;
   int         w_neg;
   int         w_pos;

   cobs_packet_arbiter #(.NUM_CHANNELS(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .m_tuser  (m_tuser),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int lg);
      for (int k = 1; k <= N; k++) begin
         if (((v >> ((lg + k) % N)) & 4'd1) != 4'd0) return (lg + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         mq.delete();
         m_lg  = N - 1;
         m_gid = 0;
      end else if (mq.size() > 0) begin
         if (m_tready) void'(mq.pop_front());
      end else begin
         w_pos = pick(s_tvalid, m_lg);
         if (w_pos >= 0) begin
            mq.push_back({1'b0, 8'(w_pos)});
            mq.push_back({1'b0, s_tdata[16*w_pos + 8 +: 8]});
            mq.push_back({1'b1, s_tdata[16*w_pos +: 8]});
            m_lg  = w_pos;
            m_gid = w_pos;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         exp_rdy = '0;
         if (mq.size() == 0) begin
            w_neg = pick(s_tvalid, m_lg);
            if (w_neg >= 0) exp_rdy = 4'(1 << w_neg);
         end
         check("s_tready", 32'(s_tready), 32'(exp_rdy));
         check("m_tvalid", 32'(m_tvalid), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            check("m_tdata", 32'(m_tdata), 32'(mq[0][7:0]));
            check("m_tlast", 32'(m_tlast), 32'(mq[0][8]));
         end
         check("busy", 32'(busy), 32'(mq.size() > 0));
         check("grant_id", 32'(grant_id), 32'(m_gid));
         check("m_tuser", 32'(m_tuser), 32'd0);
         for (int i = 0; i < N; i++) begin
            if (s_tready[i]) begin
               rdy_cnt[i]++;
               if (s_tvalid[i]) glog.push_back(i);
            end
         end
         if (m_tvalid && m_tready) begin
            blog.push_back({m_tlast, m_tdata});
            if (m_tlast) lcyc.push_back(cyc);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs;
      glog.delete();
      blog.delete();
      lcyc.delete();
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
   endtask

   task automatic do_reset;
      check_en = 1'b0;
      rst = 1'b0;
      s_tvalid = '0;
      m_tready = 1'b1;
      step(2);
      rst = 1'b1;
      clear_logs();
      check_en = 1'b1;
   endtask

   task automatic check_beats(input string name, input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
      check({name, "_count"}, 32'(blog.size()), 32'd3);
      if (blog.size() == 3) begin
         check({name, "_b0"}, 32'(blog[0]), 32'(e0));
         check({name, "_b1"}, 32'(blog[1]), 32'(e1));
         check({name, "_b2"}, 32'(blog[2]), 32'(e2));
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_tdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // 1: ch2 alone, 0x1234
      s_tdata[32 +: 16] = 16'h1234;
      s_tvalid = 4'b0100;
      step(1);
      s_tvalid = '0;
      step(5);
      check_beats("t1", 9'h002, 9'h012, 9'h134);
      check("t1_rdy2_cycles", 32'(rdy_cnt[2]), 32'd1);

      // 2: all channels continuously valid
      do_reset();
      for (int i = 0; i < N; i++) s_tdata[16*i +: 16] = 16'h0A00 + 16'(i);
      s_tvalid = 4'b1111;
      step(21);
      s_tvalid = '0;
      step(6);
      check("t2_grants", 32'(glog.size()), 32'd6);
      for (int i = 0; i < glog.size() && i < 6; i++) check("t2_order", 32'(glog[i]), 32'(i % 4));
      for (int i = 1; i < lcyc.size(); i++) check("t2_spacing", 32'(lcyc[i] - lcyc[i-1]), 32'd4);
      check("t2_beats", 32'(blog.size()), 32'd18);
      if (blog.size() == 18) begin
         check("t2_p1_id", 32'(blog[3]), 32'h001);
         check("t2_p1_hi", 32'(blog[4]), 32'h00A);
         check("t2_p1_lo", 32'(blog[5]), 32'h101);
         check("t2_p4_lo", 32'(blog[14]), 32'h100);
      end

      // 3: backpressure on the high byte of ch1
      do_reset();
      s_tdata[16 +: 16] = 16'hBEEF;
      s_tvalid = 4'b0010;
      step(1);
      s_tvalid = '0;
      for (int i = 0; i < 10 && !(m_tvalid && m_tdata == 8'hBE); i++) step(1);
      check("t3_reach_BE", 32'(m_tdata), 32'hBE);
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("t3_hold_data", 32'(m_tdata), 32'hBE);
         check("t3_hold_valid", 32'(m_tvalid), 32'd1);
      end
      m_tready = 1'b1;
      step(1);
      check("t3_next_data", 32'(m_tdata), 32'hEF);
      check("t3_next_last", 32'(m_tlast), 32'd1);
      step(3);
      check_beats("t3", 9'h001, 9'h0BE, 9'h1EF);

      // 4: all-zero packet
      do_reset();
      s_tdata[0 +: 16] = 16'h0000;
      s_tvalid = 4'b0001;
      step(1);
      s_tvalid = '0;
      step(4);
      check_beats("t4", 9'h000, 9'h000, 9'h100);
      check("t4_busy_after", 32'(busy), 32'd0);

      // 5: reset during SEND_HI of ch3
      do_reset();
      s_tdata[48 +: 16] = 16'h5678;
      s_tvalid = 4'b1000;
      step(1);
      s_tvalid = '0;
      step(1);
      check("t5_in_hi", 32'(m_tdata), 32'h56);
      check_en = 1'b0;
      rst = 1'b0;
      #1;
      check("t5_rst_valid", 32'(m_tvalid), 32'd0);
      check("t5_rst_last", 32'(m_tlast), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      step(2);
      rst = 1'b1;
      clear_logs();
      check_en = 1'b1;
      s_tdata[0 +: 16] = 16'h1111;
      s_tvalid = 4'b1001;
      step(1);
      s_tvalid = '0;
      step(4);
      check("t5_first_grant_cnt", 32'(glog.size()), 32'd1);
      if (glog.size() > 0) check("t5_first_grant", 32'(glog[0]), 32'd0);

      // 6: ch1 pulse while ch0 packet in flight
      do_reset();
      s_tdata[0 +: 16] = 16'h2222;
      s_tdata[16 +: 16] = 16'h3333;
      s_tvalid = 4'b0001;
      step(1);
      s_tvalid = 4'b0010;
      step(1);
      s_tvalid = '0;
      step(5);
      check("t6_rdy1_cycles", 32'(rdy_cnt[1]), 32'd0);
      check("t6_grants", 32'(glog.size()), 32'd1);
      check_beats("t6", 9'h000, 9'h022, 9'h122);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
